// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine: single-pass 3x3 LBP over a raster-streamed frame using two line buffers
// and a sliding window; optional zero fill of the border addresses.
module lbp_stream_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  thresh,
    input  logic              border_zero,
    output logic              busy,
    output logic              gray_req,
    input  logic              gray_ready,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] FIRST_OUT = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] FLUSH0    = ADDR_W'((IMG_H - 1) * IMG_W - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] p;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PIX_W-1:0]  thr;
    logic              bz;
    logic [PIX_W-1:0]  lb0 [IMG_W];
    logic [PIX_W-1:0]  lb1 [IMG_W];
    // win0 is the older column, win1 the centre column; index 0 = top row
    logic [2:0][PIX_W-1:0] win0, win1;
    logic [7:0][PIX_W-1:0] nb;
    logic [PIX_W:0]    limit;
    logic [7:0]        code;
    logic              fire, interior, emit, col_last;

    assign gray_req  = state == SCAN;
    assign gray_addr = gray_req ? p : '0;
    assign fire      = gray_req && gray_ready;
    assign col_last  = col == CW'(IMG_W - 1);
    assign interior  = row >= RW'(2) && col >= CW'(2);
    assign emit      = fire && p >= FIRST_OUT && (interior || bz);
    // the incoming pixel completes the right-hand column of the window
    assign nb    = {gray_data, win1[2], win0[2], lb0[col], win0[1], lb1[col], win1[0], win0[0]};
    assign limit = {1'b0, win1[1]} + {1'b0, thr};

    always_comb begin
        code = '0;
        for (int k = 0; k < 8; k++)
            code[k] = {1'b0, nb[k]} >= limit;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SCAN : IDLE;
            SCAN:    state_nx = (fire && p == LAST) ? (bz ? FLUSH : DONE) : SCAN;
            FLUSH:   state_nx = p == LAST ? DONE : FLUSH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            p         <= '0;
            col       <= '0;
            row       <= '0;
            thr       <= '0;
            bz        <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
        end else begin
            state     <= state_nx;
            finish    <= state == DONE;
            busy      <= (state == IDLE && start) || (busy && !finish);
            lbp_valid <= emit || state == FLUSH;
            if (state == IDLE && start) begin
                thr <= thresh;
                bz  <= border_zero;
                p   <= '0;
                col <= '0;
                row <= '0;
            end
            if (fire) begin
                p   <= p == LAST ? FLUSH0 : p + 1'b1;
                col <= col_last ? '0 : col + 1'b1;
                row <= col_last ? row + 1'b1 : row;
            end
            if (state == FLUSH)
                p <= p + 1'b1;
            if (emit) begin
                lbp_addr <= p - FIRST_OUT;
                lbp_data <= interior ? code : 8'd0;
            end else if (state == FLUSH) begin
                lbp_addr <= p;
                lbp_data <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            lb1[col] <= lb0[col];
            lb0[col] <= gray_data;
            win0     <= win1;
            win1     <= {gray_data, lb0[col], lb1[col]};
        end
    end
endmodule

// File: tb/tb_lbp_stream_engine.sv
// tb_lbp_stream_engine: randomized and directed frames on a 4x4 and a 16x12 instance,
// checked against a per-address LBP reference model.
module tb_lbp_stream_engine;
    logic clk = 0, reset = 1, start = 0, bz = 0, gr = 1, sel = 0;
    logic [7:0] thr = 0;
    logic [7:0] img [0:191];
    logic s_busy, s_req, s_valid, s_fin, b_busy, b_req, b_valid, b_fin;
    logic [3:0] s_addr, s_laddr;
    logic [7:0] s_ldata, b_addr, b_laddr, b_ldata;
    logic o_busy, o_req, o_valid, o_fin;
    logic [7:0] o_addr, o_laddr, o_ldata;
    int total = 0, bad = 0, cyc = 0, nfin = 0;
    int lat, sbad, tmo, busy_fin, busy_after, req0;
    logic [7:0] ga[$], gd[$], ed[$];
    int ea[$];

    always #5 clk = ~clk;

    lbp_stream_engine #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start & ~sel), .thresh(thr), .border_zero(bz),
        .busy(s_busy), .gray_req(s_req), .gray_ready(gr), .gray_addr(s_addr),
        .gray_data(img[s_addr]), .lbp_valid(s_valid), .lbp_addr(s_laddr),
        .lbp_data(s_ldata), .finish(s_fin));

    lbp_stream_engine #(.IMG_W(16), .IMG_H(12), .PIX_W(8), .ADDR_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .thresh(thr), .border_zero(bz),
        .busy(b_busy), .gray_req(b_req), .gray_ready(gr), .gray_addr(b_addr),
        .gray_data(img[b_addr]), .lbp_valid(b_valid), .lbp_addr(b_laddr),
        .lbp_data(b_ldata), .finish(b_fin));

    assign o_busy  = sel ? b_busy : s_busy;
    assign o_req   = sel ? b_req : s_req;
    assign o_valid = sel ? b_valid : s_valid;
    assign o_fin   = sel ? b_fin : s_fin;
    assign o_addr  = sel ? b_addr : {4'd0, s_addr};
    assign o_laddr = sel ? b_laddr : {4'd0, s_laddr};
    assign o_ldata = sel ? b_ldata : s_ldata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            ga.push_back(o_laddr);
            gd.push_back(o_ldata);
        end
        if (o_fin) nfin++;
    end

    // Reference: visit every address in ascending order, LBP for interior, 0 for border.
    task automatic fill_exp(input logic [7:0] t, input logic b);
        int w = sel ? 16 : 4;
        int h = sel ? 12 : 4;
        ea.delete();
        ed.delete();
        for (int a = 0; a < w * h; a++) begin
            int r = a / w;
            int c = a % w;
            if (r > 0 && r < h - 1 && c > 0 && c < w - 1) begin
                logic [7:0] code = 0;
                int k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) begin
                            code[k] = int'(img[(r + dr) * w + c + dc]) >= int'(img[a]) + int'(t);
                            k++;
                        end
                ea.push_back(a);
                ed.push_back(code);
            end else if (b) begin
                ea.push_back(a);
                ed.push_back(8'd0);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] t, input logic b, input int rnd, input int stall_p, input int spk);
        int k = 0, s0;
        logic done_st = 0;
        ga.delete();
        gd.delete();
        nfin = 0;
        sbad = 0;
        @(negedge clk);
        thr = t; bz = b; start = 1; gr = 1; s0 = cyc;
        @(negedge clk);
        start = 0;
        req0 = o_req;
        while (!o_fin && k < 4000) begin
            gr = rnd != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = k == spk;
            if (stall_p >= 0 && !done_st && o_req && o_addr == 8'(stall_p)) begin
                done_st = 1;
                gr = 0;
                repeat (3) begin
                    @(negedge clk);
                    k++;
                    if (o_addr != 8'(stall_p) || o_valid) sbad++;
                end
                gr = 1;
            end
            @(negedge clk);
            k++;
        end
        start = 0;
        tmo = !o_fin;
        lat = cyc - s0;
        busy_fin = o_busy;
        @(negedge clk);
        busy_after = o_busy;
        repeat (3) @(negedge clk);
        gr = 1;
    endtask

    task automatic test_frame(input string nm, input logic [7:0] t, input logic b, input int rnd,
                              input int stall_p, input int spk, input int xlat);
        fill_exp(t, b);
        run_frame(t, b, rnd, stall_p, spk);
        total++;
        if (tmo != 0) begin bad++; $display("FAIL %s timeout: finish never seen", nm); end
        total++;
        if (ga.size() != ea.size()) begin
            bad++; $display("FAIL %s write count: got %0d expected %0d", nm, ga.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
            total++;
            if (ga[i] !== 8'(ea[i]) || gd[i] !== ed[i]) begin
                bad++;
                $display("FAIL %s write %0d: got addr=%0d data=%02h expected addr=%0d data=%02h",
                         nm, i, ga[i], gd[i], ea[i], ed[i]);
            end
        end
        total++;
        if (nfin != 1) begin bad++; $display("FAIL %s finish pulses: got %0d expected 1", nm, nfin); end
        total++;
        if (busy_fin != 1 || busy_after != 0) begin
            bad++; $display("FAIL %s busy: at finish %0d after %0d expected 1 then 0", nm, busy_fin, busy_after);
        end
        total++;
        if (req0 != 1) begin bad++; $display("FAIL %s gray_req after start: got %0d expected 1", nm, req0); end
        if (stall_p >= 0) begin
            total++;
            if (sbad != 0) begin bad++; $display("FAIL %s stall: %0d bad stall cycles expected 0", nm, sbad); end
        end
        if (xlat >= 0) begin
            total++;
            if (lat != xlat) begin bad++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, xlat); end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({s_busy, s_req, s_valid, s_fin, s_addr, s_laddr, s_ldata} !== 0 ||
            {b_busy, b_req, b_valid, b_fin, b_addr, b_laddr, b_ldata} !== 0) begin
            bad++; $display("FAIL reset_values: got small=%h big=%h expected 0",
                {s_busy, s_req, s_valid, s_fin, s_addr, s_laddr, s_ldata},
                {b_busy, b_req, b_valid, b_fin, b_addr, b_laddr, b_ldata});
        end
        reset = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({s_busy, s_req, s_valid, s_fin, b_busy, b_req, b_valid, b_fin} !== 0) begin
            bad++; $display("FAIL idle_after_reset: got %b expected 0",
                {s_busy, s_req, s_valid, s_fin, b_busy, b_req, b_valid, b_fin});
        end
    endtask

    task automatic test_flat();
        sel = 0;
        for (int i = 0; i < 16; i++) img[i] = 10;
        test_frame("flat_t0", 0, 0, 0, -1, -1, 18);
        total++;
        if (ga.size() != 4 || ga[0] !== 8'd5 || ga[1] !== 8'd6 || ga[2] !== 8'd9 || ga[3] !== 8'd10 || gd[0] !== 8'hFF) begin
            bad++; $display("FAIL flat_t0 direct: got n=%0d first addr=%0d data=%02h expected 4, 5, ff",
                ga.size(), ga.size() > 0 ? ga[0] : 8'd0, gd.size() > 0 ? gd[0] : 8'd0);
        end
        test_frame("flat_t1", 1, 0, 0, -1, -1, 18);
        total++;
        if (gd.size() != 4 || gd[0] !== 8'h00) begin
            bad++; $display("FAIL flat_t1 direct: got n=%0d data=%02h expected 4, 00",
                gd.size(), gd.size() > 0 ? gd[0] : 8'd0);
        end
    endtask

    task automatic test_ramp_border();
        sel = 0;
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        test_frame("ramp_bz", 0, 1, 0, -1, -1, 23);
        total++;
        if (gd.size() != 16 || gd[5] !== 8'hF0 || gd[6] !== 8'hF0) begin
            bad++; $display("FAIL ramp_bz direct: got n=%0d a5=%02h a6=%02h expected 16, f0, f0",
                gd.size(), gd.size() > 6 ? gd[5] : 8'd0, gd.size() > 6 ? gd[6] : 8'd0);
        end
    endtask

    task automatic test_no_wrap();
        sel = 0;
        for (int i = 0; i < 16; i++) img[i] = 8'd255;
        img[5] = 8'd250;
        test_frame("nowrap_t10", 10, 0, 0, -1, -1, 18);
        total++;
        if (gd.size() < 1 || gd[0] !== 8'h00) begin
            bad++; $display("FAIL nowrap_t10 a5: got %02h expected 00", gd.size() > 0 ? gd[0] : 8'd0);
        end
        test_frame("nowrap_t5", 5, 0, 0, -1, -1, 18);
        total++;
        if (gd.size() < 1 || gd[0] !== 8'hFF) begin
            bad++; $display("FAIL nowrap_t5 a5: got %02h expected ff", gd.size() > 0 ? gd[0] : 8'd0);
        end
    endtask

    task automatic test_stall();
        sel = 1;
        for (int i = 0; i < 192; i++) img[i] = 8'($urandom_range(0, 255));
        test_frame("stall", 8'($urandom_range(0, 20)), 0, 0, 7, -1, 197);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            sel = n[0];
            for (int i = 0; i < 192; i++) img[i] = 8'($urandom_range(0, n < 3 ? 7 : 255));
            test_frame("random", 8'($urandom_range(0, n < 3 ? 3 : 30)), 1'($urandom_range(0, 1)), 1, -1, -1, -1);
        end
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        sel = 1;
        for (int i = 0; i < 192; i++) img[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        thr = 0; bz = 1; start = 1; gr = 1;
        @(negedge clk);
        start = 0;
        while (!(o_req && o_addr == 8'd100) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!(o_req && o_addr == 8'd100)) begin bad++; $display("FAIL midreset reach p=100: got addr=%0d", o_addr); end
        #1 reset = 1;
        #1;
        total++;
        if ({b_busy, b_req, b_valid, b_fin, b_addr} !== 0) begin
            bad++; $display("FAIL midreset outputs: got %h expected 0", {b_busy, b_req, b_valid, b_fin, b_addr});
        end
        ga.delete();
        nfin = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (6) @(negedge clk);
        total++;
        if (ga.size() != 0 || nfin != 0) begin
            bad++; $display("FAIL midreset quiet: got %0d writes %0d finishes expected 0", ga.size(), nfin);
        end
        test_frame("after_reset", 5, 0, 0, -1, 50, 194);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp_border();
        test_no_wrap();
        test_stall();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
